fft_sdf_stage5: RTL and testbench



---
 rtl/fft_sdf_stage5_pkg.sv | 26 ++
 rtl/sdf_delay_line.sv | 47 ++++
 rtl/fft_sdf_stage5.sv | 120 ++++++++++++
 tb/tb_fft_sdf_stage5.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/fft_sdf_stage5_pkg.sv
// Shared definitions for stage 5 of the 128-point radix-2 SDF FFT:
// default data widths, the mux-controller bus, sel phase encodings and
// FFT stage-count constants.
package fft_sdf_stage5_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int DELAY_DEF   = 4;
  localparam int FFT_POINTS  = 128;
  localparam int FFT_STAGES  = 7;
  localparam int STAGE_INDEX = 5;

  // Phase code driven by the stage-5 mux controller. Code 3 behaves as FLUSH.
  typedef enum logic [1:0] {
    SEL_FILL      = 2'd0,
    SEL_BFLY      = 2'd1,
    SEL_FLUSH     = 2'd2,
    SEL_FLUSH_ALT = 2'd3
  } sel_e;

  // Per-cycle control word seen by the butterfly stage.
  typedef struct packed {
    sel_e sel;
    logic din_valid;
  } mux_control_bus_t;

endpackage

// File: rtl/sdf_delay_line.sv
// Feedback delay line for the SDF stage. Each entry is {tag, re, im}. The line
// shifts once per clock, unconditionally. Entry 0 takes the push data. The
// last entry is the head, i.e. the oldest sample.
module sdf_delay_line
  import fft_sdf_stage5_pkg::*;
#(
  parameter int W     = DATA_W_DEF + 1,
  parameter int DEPTH = DELAY_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_tag,
  input  logic [W-1:0] push_re,
  input  logic [W-1:0] push_im,
  output logic         head_tag,
  output logic [W-1:0] head_re,
  output logic [W-1:0] head_im
);

  logic [DEPTH-1:0] tag_q;
  logic [W-1:0]     re_q [DEPTH];
  logic [W-1:0]     im_q [DEPTH];

  // Shift every entry one place toward the head; reset empties the line.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        re_q[i] <= '0;
        im_q[i] <= '0;
      end
    end else begin
      tag_q <= {tag_q[DEPTH-2:0], push_tag};
      re_q[0] <= push_re;
      im_q[0] <= push_im;
      for (int i = 1; i < DEPTH; i++) begin
        re_q[i] <= re_q[i-1];
        im_q[i] <= im_q[i-1];
      end
    end
  end

  assign head_tag = tag_q[DEPTH-1];
  assign head_re  = re_q[DEPTH-1];
  assign head_im  = im_q[DEPTH-1];

endmodule

// File: rtl/fft_sdf_stage5.sv
// Radix-2 SDF butterfly, stage 5 of the 128-point streaming FFT.
// Optional feature macro FFT_STAGE_ROUND_SCALE_EN: when defined, every output
// value is scaled by (v+1)>>>1 (round half up). Delay-line contents stay
// unscaled.
//
// Stream semantics: valid-only, with no backpressure. din_valid qualifies the
// input sample on every clock. dout_valid qualifies the registered output one
// clock later. The consumer must accept every qualified output.
module fft_sdf_stage5
  import fft_sdf_stage5_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DELAY  = DELAY_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        sel,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] din_re,
  input  logic [DATA_W-1:0] din_im,
  output logic              dout_valid,
  output logic [DATA_W:0]   dout_re,
  output logic [DATA_W:0]   dout_im
);

  localparam int OW = DATA_W + 1;

  mux_control_bus_t ctl;
  logic          head_tag;
  logic [OW-1:0] head_re, head_im;
  logic [OW-1:0] din_re_x, din_im_x;
  logic [OW-1:0] sum_re, sum_im, diff_re, diff_im;
  logic          push_tag;
  logic [OW-1:0] push_re, push_im;
  logic          nxt_tag;
  logic [OW-1:0] nxt_re, nxt_im;

  assign ctl.sel       = sel_e'(sel);
  assign ctl.din_valid = din_valid;

  assign din_re_x = {din_re[DATA_W-1], din_re};
  assign din_im_x = {din_im[DATA_W-1], din_im};

  // The butterfly result is kept at DATA_W+1 bits, which is the same as
  // computing at DATA_W+2 bits and then truncating. The head always holds a
  // sign-extended FILL sample, so the true sum and difference fit in
  // DATA_W+1 bits and no wrap can occur.
  assign sum_re  = head_re + din_re_x;
  assign sum_im  = head_im + din_im_x;
  assign diff_re = head_re - din_re_x;
  assign diff_im = head_im - din_im_x;

`ifdef FFT_STAGE_ROUND_SCALE_EN
  function automatic logic [OW-1:0] out_scale(input logic [OW-1:0] v);
    logic [OW:0] t;
    t = {v[OW-1], v} + {{OW{1'b0}}, 1'b1};
    return t[OW:1];
  endfunction
`else
  function automatic logic [OW-1:0] out_scale(input logic [OW-1:0] v);
    return v;
  endfunction
`endif

  // Per-phase selection of the delay-line push and the next output value.
  always_comb begin
    push_tag = 1'b0;
    push_re  = '0;
    push_im  = '0;
    nxt_tag  = head_tag;
    nxt_re   = head_re;
    nxt_im   = head_im;
    case (ctl.sel)
      SEL_FILL: begin
        push_tag = ctl.din_valid;
        push_re  = din_re_x;
        push_im  = din_im_x;
      end
      SEL_BFLY: begin
        push_tag = head_tag & ctl.din_valid;
        push_re  = diff_re;
        push_im  = diff_im;
        nxt_tag  = head_tag & ctl.din_valid;
        nxt_re   = sum_re;
        nxt_im   = sum_im;
      end
      default: begin
        push_tag = 1'b0;
      end
    endcase
  end

  sdf_delay_line #(
    .W     (OW),
    .DEPTH (DELAY)
  ) u_delay (
    .clk      (clk),
    .rst      (rst),
    .push_tag (push_tag),
    .push_re  (push_re),
    .push_im  (push_im),
    .head_tag (head_tag),
    .head_re  (head_re),
    .head_im  (head_im)
  );

  // Output register: one cycle of latency from the sel/din sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_valid <= 1'b0;
      dout_re    <= '0;
      dout_im    <= '0;
    end else begin
      dout_valid <= nxt_tag;
      dout_re    <= out_scale(nxt_re);
      dout_im    <= out_scale(nxt_im);
    end
  end

endmodule

// File: tb/tb_fft_sdf_stage5.sv
// Directed testbench for fft_sdf_stage5 (DATA_W=16, DELAY=4). When
// FFT_STAGE_ROUND_SCALE_EN is defined, the expected outputs are rescaled.
module tb_fft_sdf_stage5;

  localparam int DATA_W = 16;
  localparam int OW     = DATA_W + 1;
  localparam logic [1:0] FILL  = 2'd0;
  localparam logic [1:0] BFLY  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        sel;
  logic              din_valid;
  logic [DATA_W-1:0] din_re, din_im;
  logic              dout_valid;
  logic [DATA_W:0]   dout_re, dout_im;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_n    = 0;

  // Each queue entry is {check_data, valid, re[16:0], im[16:0]}.
  logic [2*OW+1:0] exp_q[$];

  // Clock / DUT
  always #5 clk = ~clk;

  fft_sdf_stage5 #(.DATA_W(DATA_W), .DELAY(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .sel        (sel),
    .din_valid  (din_valid),
    .din_re     (din_re),
    .din_im     (din_im),
    .dout_valid (dout_valid),
    .dout_re    (dout_re),
    .dout_im    (dout_im)
  );

  function automatic int scl(input int v);
`ifdef FFT_STAGE_ROUND_SCALE_EN
    return (v + 1) >>> 1;
`else
    return v;
`endif
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Queue the expected output for one driven cycle.
  task automatic expect_out(input bit chk, input bit v, input int re, input int im);
    logic [31:0] r, i;
    r = scl(re);
    i = scl(im);
    exp_q.push_back({chk, v, r[OW-1:0], i[OW-1:0]});
  endtask

  // Drive one sample, then compare the registered output against the queue head.
  task automatic cyc(input bit r, input logic [1:0] s, input bit v, input int re, input int im);
    logic [2*OW+1:0]   e;
    logic signed [OW-1:0] er, ei;
    rst = r; sel = s; din_valid = v;
    din_re = re[DATA_W-1:0];
    din_im = im[DATA_W-1:0];
    @(posedge clk);
    #1;
    cyc_n++;
    if (exp_q.size() == 0) begin
      check($sformatf("c%0d_exp_q_empty", cyc_n), 1, 0);
    end else begin
      e  = exp_q.pop_front();
      er = e[2*OW-1:OW];
      ei = e[OW-1:0];
      check($sformatf("c%0d_valid", cyc_n), {31'd0, dout_valid}, {31'd0, e[2*OW]});
      if (e[2*OW+1]) begin
        check($sformatf("c%0d_re", cyc_n), $signed(dout_re), er);
        check($sformatf("c%0d_im", cyc_n), $signed(dout_im), ei);
      end
    end
  endtask

  initial begin
    rst = 1'b1; sel = FILL; din_valid = 1'b0; din_re = '0; din_im = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", {31'd0, dout_valid}, 0);
    check("reset_re", $signed(dout_re), 0);
    check("reset_im", $signed(dout_im), 0);

    // Basic pair
    for (int k = 0; k < 4; k++) expect_out(1, 0, 0, 0);
    expect_out(1, 1, 11, 0); expect_out(1, 1, 22, 0);
    expect_out(1, 1, 33, 0); expect_out(1, 1, 44, 0);
    expect_out(1, 1, -9, 0); expect_out(1, 1, -18, 0);
    expect_out(1, 1, -27, 0); expect_out(1, 1, -36, 0);
    for (int k = 1; k <= 4; k++) cyc(0, FILL, 1, k, 0);
    for (int k = 1; k <= 4; k++) cyc(0, BFLY, 1, 10 * k, 0);
    for (int k = 0; k < 4; k++) cyc(0, FILL, 0, 0, 0);

    // Extremes: 17-bit sums and differences must not wrap
    for (int k = 0; k < 4; k++) expect_out(1, 0, 0, 0);
    expect_out(1, 1, 65534, 0); expect_out(1, 1, -1, 0);
    expect_out(1, 1, 0, 0);     expect_out(1, 1, 0, 0);
    expect_out(1, 1, 0, 0);     expect_out(1, 1, -65535, 0);
    expect_out(1, 1, 0, 0);     expect_out(1, 1, 0, 0);
    cyc(0, FILL, 1, 32767, 0); cyc(0, FILL, 1, -32768, 0);
    cyc(0, FILL, 1, 0, 0);     cyc(0, FILL, 1, 0, 0);
    cyc(0, BFLY, 1, 32767, 0); cyc(0, BFLY, 1, 32767, 0);
    cyc(0, BFLY, 1, 0, 0);     cyc(0, BFLY, 1, 0, 0);
    for (int k = 0; k < 4; k++) cyc(0, FILL, 0, 0, 0);

    // Tag gating with imaginary data, then flush
    for (int k = 0; k < 4; k++) expect_out(1, 0, 0, 0);
    expect_out(1, 1, 101, 5);    expect_out(0, 0, 202, 26);
    expect_out(1, 1, 303, 23);   expect_out(1, 1, 404, 48);
    expect_out(1, 1, -99, -15);  expect_out(0, 0, -198, -14);
    expect_out(1, 1, -297, -37); expect_out(1, 1, -396, -32);
    for (int k = 0; k < 4; k++) expect_out(1, 0, 0, 0);
    cyc(0, FILL, 1, 1, -5); cyc(0, FILL, 0, 2, 6);
    cyc(0, FILL, 1, 3, -7); cyc(0, FILL, 1, 4, 8);
    for (int k = 1; k <= 4; k++) cyc(0, BFLY, 1, 100 * k, 10 * k);
    for (int k = 0; k < 4; k++) cyc(0, FLUSH, 0, 0, 0);
    for (int k = 0; k < 4; k++) cyc(0, (k % 2 == 0) ? FLUSH : 2'd3, 1, 7, 7);

    // Reset mid-frame during BFLY, then a clean frame
    for (int k = 0; k < 4; k++) expect_out(1, 0, 0, 0);
    expect_out(1, 1, 55, 0); expect_out(1, 1, 66, 0);
    expect_out(1, 0, 0, 0);
    for (int k = 0; k < 4; k++) expect_out(1, 0, 0, 0);
    expect_out(1, 1, 10, 0); expect_out(1, 1, 11, 0);
    expect_out(1, 1, 12, 0); expect_out(1, 1, 13, 0);
    expect_out(1, 1, 8, 0);  expect_out(1, 1, 9, 0);
    expect_out(1, 1, 10, 0); expect_out(1, 1, 11, 0);
    for (int k = 5; k <= 8; k++) cyc(0, FILL, 1, k, 0);
    cyc(0, BFLY, 1, 50, 0); cyc(0, BFLY, 1, 60, 0);
    cyc(1, BFLY, 1, 70, 0);
    for (int k = 9; k <= 12; k++) cyc(0, FILL, 1, k, 0);
    for (int k = 0; k < 4; k++) cyc(0, BFLY, 1, 1, 0);
    for (int k = 0; k < 4; k++) cyc(0, FILL, 0, 0, 0);

    check("exp_q_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
